sram_arbiter: RTL and testbench

- Parametrised successor to the single-port memory controller.
- Arbitrates NCH independent requesters onto the single external SRAM bus (va/vd/n_vrd/n_vwr). Typical requesters: screen fetch, CPU, ROM-to-RAM loader, DMA.
- Channel 0 has fixed highest priority. Channels 1..NCH-1 share the remaining bandwidth round-robin.
- Each access is a latched, multi-cycle SRAM cycle with an explicit req/ack handshake, replacing the old purely combinational bus steering.

---
 rtl/sram_arbiter_if.sv | 33 +++
 rtl/sram_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// SRAM arbiter bus: requester channels on one side,
// external SRAM pad signals on the other.
interface sram_arbiter_if #(
  parameter int NCH = 4,
  parameter int AW  = 19,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic [AW-1:0]     va;
  logic [DW-1:0]     vd_i;
  logic [DW-1:0]     vd_o;
  logic              vd_oe;
  logic              n_vrd;
  logic              n_vwr;

  modport slave (
    input  req, we, addr, wdata, vd_i,
    output ack, rdata, busy, va, vd_o,
    output vd_oe, n_vrd, n_vwr
  );

  modport master (
    output req, we, addr, wdata, vd_i,
    input  ack, rdata, busy, va, vd_o,
    input  vd_oe, n_vrd, n_vwr
  );
endinterface

// File: rtl/sram_arbiter.sv
// Multi-channel SRAM arbiter: ch0 fixed priority,
// ch1..NCH-1 round-robin, latched multi-cycle accesses.
module sram_arbiter #(
  parameter int NCH        = 4,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int ACCESS_CYC = 3
) (
  input  logic           clk28,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NCH);
  localparam int CW = (ACCESS_CYC > 2) ?
                      $clog2(ACCESS_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(ACCESS_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_rr;
  logic [PW-1:0] r_gnt;
  logic          r_we;
  logic [AW-1:0] r_va;
  logic [DW-1:0] r_vd_o;
  logic          r_vd_oe;
  logic          r_n_vrd;
  logic          r_n_vwr;
  logic [NCH-1:0] r_ack;
  logic [DW-1:0] r_rdata;
  logic          r_busy;

  logic          w_gnt_vld;
  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_rr_nxt;
  logic          w_we_g;
  logic [AW-1:0] w_addr_g;
  logic [DW-1:0] w_wdata_g;

  // Position k of the round-robin scan starting at p,
  // confined to channels 1..NCH-1.
  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] p,
    input int            k
  );
    return PW'(((int'(p) - 1 + k) % (NCH - 1)) + 1);
  endfunction

  // Grant selection: ch0 first, then scan from r_rr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (bus.req[0]) begin
      w_gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < NCH - 1; k++) begin
        if (!w_gnt_vld && bus.req[rr_idx(r_rr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = rr_idx(r_rr, k);
        end
      end
    end
  end

  // Pointer moves past the granted channel, wrapping to 1.
  always_comb begin
    w_rr_nxt = (int'(w_gnt) + 1 >= NCH) ?
               PW'(1) : w_gnt + PW'(1);
  end

  // Granted channel's request fields.
  always_comb begin
    w_we_g    = bus.we[w_gnt];
    w_addr_g  = bus.addr[int'(w_gnt)*AW +: AW];
    w_wdata_g = bus.wdata[int'(w_gnt)*DW +: DW];
  end

  // Access FSM with all bus strobes registered.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rr    <= PW'(1);
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_va    <= '0;
      r_vd_o  <= '0;
      r_vd_oe <= 1'b0;
      r_n_vrd <= 1'b1;
      r_n_vwr <= 1'b1;
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_state <= ACCESS;
            r_cnt   <= '0;
            r_gnt   <= w_gnt;
            r_we    <= w_we_g;
            r_va    <= w_addr_g;
            r_vd_o  <= w_wdata_g;
            r_vd_oe <= w_we_g;
            r_n_vrd <= w_we_g;
            r_n_vwr <= 1'b1;
            r_busy  <= 1'b1;
            if (w_gnt != '0) r_rr <= w_rr_nxt;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            r_state      <= RECOVER;
            r_n_vrd      <= 1'b1;
            r_n_vwr      <= 1'b1;
            r_ack[r_gnt] <= 1'b1;
            if (!r_we) r_rdata <= bus.vd_i;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_n_vwr <= !r_we;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
          r_vd_oe <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign bus.busy  = r_busy;
  assign bus.va    = r_va;
  assign bus.vd_o  = r_vd_o;
  assign bus.vd_oe = r_vd_oe;
  assign bus.n_vrd = r_n_vrd;
  assign bus.n_vwr = r_n_vwr;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an
// ack/rdata scoreboard.
module tb_sram_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 19;
  localparam int DW  = 8;
  localparam int AC  = 3;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } exp_t;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] key = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_cnt [NCH];
  logic [DW-1:0] last_rd = '0;
  exp_t sb [$];

  sram_arbiter_if #(
    .NCH(NCH), .AW(AW), .DW(DW)
  ) bus_if ();

  sram_arbiter #(
    .NCH(NCH), .AW(AW), .DW(DW), .ACCESS_CYC(AC)
  ) u_dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk28 = ~clk28;

  // Pad model: read data derived from the address.
  assign bus_if.vd_i = bus_if.va[7:0] ^ key;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic push_exp(
    input int          ch,
    input bit          wr,
    input logic [18:0] a
  );
    exp_t e;
    if (!wr) last_rd = a[7:0] ^ key;
    e.ch   = ch;
    e.data = last_rd;
    sb.push_back(e);
  endtask

  task automatic issue(
    input int          ch,
    input bit          wr,
    input logic [18:0] a,
    input logic [7:0]  d
  );
    bus_if.we[ch]              = wr;
    bus_if.addr[ch*AW +: AW]   = a;
    bus_if.wdata[ch*DW +: DW]  = d;
    bus_if.req[ch]             = 1'b1;
    push_exp(ch, wr, a);
  endtask

  task automatic wait_ack(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_if.ack[ch] && n < 20);
  endtask

  // Scoreboard and bus-safety monitor.
  always @(negedge clk28) begin : mon
    exp_t e;
    chk("rd_wr_overlap",
        !(!bus_if.n_vrd && !bus_if.n_vwr), 1);
    chk("oe_during_rd",
        !(bus_if.vd_oe && !bus_if.n_vrd), 1);
    if (bus_if.ack != '0) begin
      chk("ack_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_ch", bus_if.ack, 32'(1) << e.ch);
        chk("rdata", bus_if.rdata, e.data);
      end
      for (int i = 0; i < NCH; i++)
        if (bus_if.ack[i]) ack_cnt[i]++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int a2;
    for (int i = 0; i < NCH; i++) ack_cnt[i] = 0;
    bus_if.req   = '0;
    bus_if.we    = '0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_va", bus_if.va, 0);
    chk("rst_n_vrd", bus_if.n_vrd, 1);
    chk("rst_n_vwr", bus_if.n_vwr, 1);
    chk("rst_vd_oe", bus_if.vd_oe, 0);
    chk("rst_vd_o", bus_if.vd_o, 0);
    chk("rst_ack", bus_if.ack, 0);
    chk("rst_rdata", bus_if.rdata, 0);
    chk("rst_busy", bus_if.busy, 0);
    rst_n = 1'b1;
    tick();

    // Single read on ch1
    key = 8'h86;
    issue(1, 1'b0, 19'h7C123, 8'h00);
    tick();
    chk("rd_va", bus_if.va, 19'h7C123);
    chk("rd_busy", bus_if.busy, 1);
    chk("rd_oe", bus_if.vd_oe, 0);
    for (int c = 0; c < AC; c++) begin
      chk("rd_n_vrd_low", bus_if.n_vrd, 0);
      if (c != 0) chk("rd_va_hold", bus_if.va, 19'h7C123);
      tick();
    end
    chk("rd_ack_lat", bus_if.ack, 4'b0010);
    chk("rd_n_vrd_rec", bus_if.n_vrd, 1);
    chk("rd_rdata", bus_if.rdata, 8'hA5);
    bus_if.req[1] = 1'b0;
    tick();
    chk("rd_idle", bus_if.busy, 0);
    tick();

    // Single write on ch2
    issue(2, 1'b1, 19'h00010, 8'h3C);
    for (int k = 1; k <= AC + 1; k++) begin
      tick();
      chk("wr_oe", bus_if.vd_oe, 1);
      chk("wr_vd_o", bus_if.vd_o, 8'h3C);
      chk("wr_va", bus_if.va, 19'h00010);
      chk("wr_n_vrd", bus_if.n_vrd, 1);
      chk("wr_n_vwr", bus_if.n_vwr,
          (k >= 2 && k <= AC) ? 0 : 1);
    end
    chk("wr_ack", bus_if.ack, 4'b0100);
    bus_if.req[2] = 1'b0;
    tick();
    chk("wr_oe_drop", bus_if.vd_oe, 0);
    chk("wr_ack_once", bus_if.ack, 0);
    tick();

    // Priority: ch0 and ch3 together
    key = 8'h5A;
    issue(0, 1'b0, 19'h00100, 8'h00);
    issue(3, 1'b0, 19'h00333, 8'h00);
    wait_ack(0, n);
    chk("pri_ch0_lat", n, AC + 1);
    bus_if.req[0] = 1'b0;
    wait_ack(3, n);
    chk("pri_ch3_lat", n, AC + 2);
    bus_if.req[3] = 1'b0;
    tick();
    tick();

    // Round-robin among ch1..ch3
    key = 8'hC3;
    issue(1, 1'b0, 19'h11111, 8'h00);
    issue(2, 1'b0, 19'h22222, 8'h00);
    issue(3, 1'b0, 19'h33333, 8'h00);
    push_exp(1, 1'b0, 19'h11111);
    push_exp(2, 1'b0, 19'h22222);
    push_exp(3, 1'b0, 19'h33333);
    for (int i = 0; i < 6; i++) begin
      wait_ack(1 + (i % 3), n);
      chk("rr_period", n, (i == 0) ? AC + 1 : AC + 2);
    end
    bus_if.req = '0;
    tick();
    tick();

    // Withdrawal: ch2 pulse during ch0 access
    a2 = ack_cnt[2];
    issue(0, 1'b0, 19'h0F0F0, 8'h00);
    tick();
    bus_if.we[2]  = 1'b0;
    bus_if.req[2] = 1'b1;
    tick();
    bus_if.req[2] = 1'b0;
    wait_ack(0, n);
    chk("wd_ch0_lat", n, AC - 1);
    bus_if.req[0] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("wd_idle", bus_if.busy, 0);
    chk("wd_no_ack2", ack_cnt[2], a2);

    // Reset during a ch1 write at cnt=1
    bus_if.we[1]             = 1'b1;
    bus_if.addr[1*AW +: AW]  = 19'h00ABC;
    bus_if.wdata[1*DW +: DW] = 8'h77;
    bus_if.req[1]            = 1'b1;
    tick();
    tick();
    chk("rs_pre_n_vwr", bus_if.n_vwr, 0);
    rst_n = 1'b0;
    #1;
    chk("rs_n_vwr", bus_if.n_vwr, 1);
    chk("rs_vd_oe", bus_if.vd_oe, 0);
    chk("rs_busy", bus_if.busy, 0);
    chk("rs_va", bus_if.va, 0);
    chk("rs_rdata", bus_if.rdata, 0);
    bus_if.req[1] = 1'b0;
    last_rd = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_idle", bus_if.busy, 0);

    // rr_ptr back at 1: ch1 wins over ch2
    key = 8'h3E;
    issue(1, 1'b0, 19'h01234, 8'h00);
    issue(2, 1'b0, 19'h05678, 8'h00);
    wait_ack(1, n);
    chk("rs_rr_ch1", n, AC + 1);
    bus_if.req[1] = 1'b0;
    wait_ack(2, n);
    chk("rs_rr_ch2", n, AC + 2);
    bus_if.req[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
